// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
// Shared types and constants for the two-client SDRAM port arbiter:
//   - arb_state_e  : transaction FSM states (IDLE/ISSUE/BURST/HOLDOFF)
//   - client_idx_t : index of a client (0 = c0, 1 = c1)
//   - BURST_LEN_DEF: default read burst length in words
//   - beat_w()     : width of the burst beat counter for a given burst length
package sdram_arb_pkg;

   localparam int BURST_LEN_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      BURST   = 2'd2,
      HOLDOFF = 2'd3
   } arb_state_e;

   typedef logic client_idx_t;

   // $clog2 of the burst length, never narrower than one bit so that a
   // single-word burst still gets a legal counter vector.
   function automatic int beat_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int BEAT_W_DEF = beat_w(BURST_LEN_DEF);

endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick
// Combinational winner selection for the two-client SDRAM arbiter.
// Build option: SDRAM_ARB_ROUND_ROBIN_EN
//   defined     : a tie goes to the client that did not win last time
//   not defined : fixed priority, c0 wins every tie (no last-winner input)
// Ports:
//   req_i         in  2 : {c1_req, c0_req}
//   last_winner_i in  1 : previous grant (round-robin build only)
//   any_o         out 1 : at least one client is requesting
//   winner_o      out 1 : index of the selected client (valid when any_o)
module sdram_arb_pick
   import sdram_arb_pkg::*;
(
   input  logic [1:0]  req_i,
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   input  client_idx_t last_winner_i,
`endif
   output logic        any_o,
   output client_idx_t winner_o
);

   always_comb begin
      any_o    = |req_i;
      winner_o = 1'b0;
      if (req_i == 2'b10) begin
         winner_o = 1'b1;
      end else if (req_i == 2'b11) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
         winner_o = ~last_winner_i;
`else
         winner_o = 1'b0;
`endif
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one SDRAM controller port between two burst clients (instruction
// and data caches). The winning request is latched and held on the
// controller port until its completion; fill / write-ack strobes are
// steered combinationally to the granted client only. After each
// transaction one HOLDOFF cycle gives the granted client time to drop its
// registered request before arbitration resumes.
// Build option: SDRAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (default build is fixed priority, c0 first).
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   cN_req/cN_addr/cN_rw/cN_wdata  : client requests (rw 1 = read)
//   cN_fill, cN_wack               : per-client burst start / write done
//   c_rdata                        : controller read data, broadcast
//   mem_req/mem_addr/mem_rw/mem_wdata : request to the SDRAM controller
//   mem_fill, mem_wack, mem_rdata  : controller responses
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c0_req,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic              c0_rw,
   input  logic [DATA_W-1:0] c0_wdata,
   input  logic              c1_req,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic              c1_rw,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c0_fill,
   output logic              c1_fill,
   output logic              c0_wack,
   output logic              c1_wack,
   output logic [DATA_W-1:0] c_rdata,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rw,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_fill,
   input  logic              mem_wack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int BW = beat_w(BURST_LEN);

   arb_state_e        state_q, state_d;
   client_idx_t       grant_q, grant_d;
   logic [BW-1:0]     beat_ctr_q, beat_ctr_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rw_q, mem_rw_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              pick_any;
   client_idx_t       pick_winner;

   // Completions only count while a request is outstanding and only when
   // they match the direction of that request; everything else is dropped.
   logic              fill_hit;
   logic              wack_hit;

   assign fill_hit = (state_q == ISSUE) &&  mem_rw_q && mem_fill;
   assign wack_hit = (state_q == ISSUE) && !mem_rw_q && mem_wack;

   assign c0_fill   = fill_hit && (grant_q == 1'b0);
   assign c1_fill   = fill_hit && (grant_q == 1'b1);
   assign c0_wack   = wack_hit && (grant_q == 1'b0);
   assign c1_wack   = wack_hit && (grant_q == 1'b1);
   assign c_rdata   = mem_rdata;

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_rw    = mem_rw_q;
   assign mem_wdata = mem_wdata_q;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   client_idx_t last_winner_q, last_winner_d;

   sdram_arb_pick u_pick (
      .req_i         ({c1_req, c0_req}),
      .last_winner_i (last_winner_q),
      .any_o         (pick_any),
      .winner_o      (pick_winner)
   );

   always_comb begin
      last_winner_d = last_winner_q;
      if ((state_q == IDLE) && pick_any) begin
         last_winner_d = pick_winner;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_winner_q <= 1'b1;   // makes c0 the first tie winner
      end else begin
         last_winner_q <= last_winner_d;
      end
   end
`else
   sdram_arb_pick u_pick (
      .req_i    ({c1_req, c0_req}),
      .any_o    (pick_any),
      .winner_o (pick_winner)
   );
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      beat_ctr_d  = beat_ctr_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_rw_d    = mem_rw_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d     = pick_winner;
               mem_req_d   = 1'b1;
               mem_addr_d  = pick_winner ? c1_addr  : c0_addr;
               mem_rw_d    = pick_winner ? c1_rw    : c0_rw;
               mem_wdata_d = pick_winner ? c1_wdata : c0_wdata;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (fill_hit) begin
               mem_req_d  = 1'b0;
               beat_ctr_d = BW'(BURST_LEN - 1);
               // The fill cycle itself carries the first word; a one-word
               // burst therefore has no BURST phase at all.
               state_d    = (BURST_LEN > 1) ? BURST : HOLDOFF;
            end else if (wack_hit) begin
               mem_req_d = 1'b0;
               state_d   = HOLDOFF;
            end
         end
         BURST: begin
            beat_ctr_d = beat_ctr_q - BW'(1);
            if (beat_ctr_q <= BW'(1)) begin
               state_d = HOLDOFF;
            end
         end
         HOLDOFF: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         beat_ctr_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_rw_q    <= 1'b1;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         beat_ctr_q  <= beat_ctr_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_rw_q    <= mem_rw_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule
